// File: rtl/sort_arbiter.sv
// Round-robin front end that shares one external sorter between N_REQ requesters.
// Define SORT_ARB_TIMEOUT_EN to add a watchdog that aborts a job stuck waiting on the sorter.
module sort_arbiter #(
    parameter int N       = 6,
    parameter int WIDTH   = 8,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0][N-1:0][WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]                     gnt,
    output logic                                 sort_start,
    output logic [N-1:0][WIDTH-1:0]              sort_data,
    input  logic                                 sort_done,
    input  logic [N-1:0][WIDTH-1:0]              sort_result,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [ID_W-1:0]                      rsp_id,
    output logic [N-1:0][WIDTH-1:0]              rsp_data,
    output logic                                 rsp_err,
    output logic                                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         win_q;
    logic [ID_W-1:0]         pick_idx;
    logic [ID_W-1:0]         next_ptr;
    logic                    pick_valid;
    logic [N-1:0][WIDTH-1:0] operand_q;
    logic [N-1:0][WIDTH-1:0] rsp_data_q;
    logic                    wdog_expired;

`ifdef SORT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wdog_q;
    logic             err_q;

    assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT - 1));
    assign rsp_err      = err_q;
`else
    assign wdog_expired = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // Scan from rr_ptr upward (wrapping) and take the first active request.
    always_comb begin : arbitrate
        int cand;
        cand       = 0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!pick_valid && req[cand[ID_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[ID_W-1:0];
            end
        end
        if (pick_idx == ID_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = pick_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt        = '0;
        sort_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                gnt[win_q] = 1'b1;
                state_d    = START;
            end
            START: begin
                sort_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (sort_done || wdog_expired) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand and winner are latched only at arbitration, so sort_data is frozen for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            win_q      <= '0;
            operand_q  <= '0;
            rsp_data_q <= '0;
        end else begin
            if (state_q == IDLE && pick_valid) begin
                operand_q <= req_data[pick_idx];
                win_q     <= pick_idx;
                rr_ptr    <= next_ptr;
            end
            if (state_q == WAIT) begin
                if (sort_done) begin
                    rsp_data_q <= sort_result;
                end else if (wdog_expired) begin
                    rsp_data_q <= '0;
                end
            end
        end
    end

`ifdef SORT_ARB_TIMEOUT_EN
    // sort_done has priority over an expiry landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == START) begin
                wdog_q <= '0;
            end else if (state_q == WAIT) begin
                wdog_q <= wdog_q + CNT_W'(1);
            end
            if (state_q == WAIT) begin
                if (sort_done) begin
                    err_q <= 1'b0;
                end else if (wdog_expired) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`endif

    assign sort_data = operand_q;
    assign rsp_id    = win_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter with a behavioural 7-state sorter and a response scoreboard.
module tb_sort_arbiter;

    localparam int N     = 6;
    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef logic [N-1:0][WIDTH-1:0] vec_t;

    typedef struct {
        int   id;
        vec_t data;
        bit   err;
    } rsp_t;

    logic                               clk;
    logic                               rst_n;
    logic [N_REQ-1:0]                   req;
    logic [N_REQ-1:0][N-1:0][WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                   gnt;
    logic                               sort_start;
    vec_t                               sort_data;
    logic                               sort_done;
    vec_t                               sort_result;
    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    vec_t                               rsp_data;
    logic                               rsp_err;
    logic                               busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_rsp[$];
    int   exp_gnt[$];

    bit   sorter_hang;
    bit   spur_done;
    bit   spur_en;
    vec_t spur_result;
    vec_t sorter_buf;
    vec_t sorter_res;
    logic sorter_done_q;
    int   sorter_cnt;

    sort_arbiter #(
        .N       (N),
        .WIDTH   (WIDTH),
        .N_REQ   (N_REQ),
        .TIMEOUT (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .sort_start  (sort_start),
        .sort_data   (sort_data),
        .sort_done   (sort_done),
        .sort_result (sort_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ordering: smallest element ends up in the most significant slot.
    function automatic vec_t sort_vec(input vec_t v);
        logic [WIDTH-1:0] a [N];
        logic [WIDTH-1:0] t;
        vec_t r;
        for (int i = 0; i < N; i++) a[i] = v[i];
        for (int i = 0; i < N - 1; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[N-1-i] = a[i];
        return r;
    endfunction

    // Sorter model: done pulse 8 cycles after the start pulse, same reset net as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sorter_cnt    <= 0;
            sorter_done_q <= 1'b0;
            sorter_buf    <= '0;
            sorter_res    <= '0;
        end else begin
            sorter_done_q <= 1'b0;
            if (sort_start) begin
                sorter_cnt <= 1;
                sorter_buf <= sort_vec(sort_data);
            end else if (sorter_cnt == 7) begin
                sorter_cnt <= 0;
                if (!sorter_hang) begin
                    sorter_done_q <= 1'b1;
                    sorter_res    <= sorter_buf;
                end
            end else if (sorter_cnt != 0) begin
                sorter_cnt <= sorter_cnt + 1;
            end
        end
    end

    assign sort_done   = sorter_done_q | spur_done;
    assign sort_result = spur_en ? spur_result : sorter_res;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int id, input vec_t data, input vec_t exp_data,
                                 input bit exp_err, input bit expect_rsp);
        rsp_t r;
        req_data[id] = data;
        req[id]      = 1'b1;
        exp_gnt.push_back(id);
        if (expect_rsp) begin
            r.id   = id;
            r.data = exp_data;
            r.err  = exp_err;
            exp_rsp.push_back(r);
        end
    endtask

    task automatic waitResponse(input int budget, output int lat, output int gnt_at,
                                output int start_at, output int start_cnt);
        lat = -1; gnt_at = -1; start_at = -1; start_cnt = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (gnt_at < 0) gnt_at = c;
                req = req & ~gnt;
            end
            if (sort_start) begin
                start_cnt++;
                if (start_at < 0) start_at = c;
            end
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy && exp_rsp.size() == 0) break;
        end
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_queue"}, exp_rsp.size(), 0);
    endtask

    // Scoreboard: grants and accepted responses are popped against what the stimulus pushed.
    always @(negedge clk) begin : monitor
        rsp_t ex;
        int   eg;
        if (rst_n) begin
            if (gnt != '0) begin
                if (exp_gnt.size() == 0) begin
                    checkOutput("gnt_unexpected", gnt, 0);
                end else begin
                    eg = exp_gnt.pop_front();
                    checkOutput("gnt_onehot", gnt, 64'(1) << eg);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    checkOutput("rsp_unexpected", rsp_valid, 0);
                end else begin
                    ex = exp_rsp.pop_front();
                    checkOutput("rsp_id", rsp_id, ex.id);
                    checkOutput("rsp_data", rsp_data, ex.data);
                    checkOutput("rsp_err", rsp_err, ex.err);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t d, d2, e, dup, dup_exp;
        vec_t fd [N_REQ];
        int   lat, gat, sat, scnt, cnt, stable;

        rst_n = 1'b0; req = '0; req_data = '0; rsp_ready = 1'b0;
        sorter_hang = 1'b0; spur_done = 1'b0; spur_en = 1'b0; spur_result = '0;
        #3;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_start", sort_start, 0);
        checkOutput("reset_valid", rsp_valid, 0);
        checkOutput("reset_err", rsp_err, 0);
        checkOutput("reset_id", rsp_id, 0);
        checkOutput("reset_data", rsp_data, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] single request");
        d = {8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
        e = {8'd1, 8'd2, 8'd3, 8'd5, 8'd7, 8'd9};
        applyStimulus(0, d, e, 1'b0, 1'b1);
        waitResponse(40, lat, gat, sat, scnt);
        checkOutput("single_latency", lat, 11);
        checkOutput("single_gnt_cycle", gat, 1);
        checkOutput("single_start_cycle", sat, 2);
        checkOutput("single_start_pulses", scnt, 1);
        checkOutput("single_sort_data", sort_data, d);
        repeat (3) @(negedge clk);
        checkOutput("single_hold_valid", rsp_valid, 1);
        checkOutput("single_hold_data", rsp_data, e);
        tick(); rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        tick();

        $display("[TB] fairness");
        for (int r = 0; r < N_REQ; r++) begin
            for (int k = 0; k < N; k++) fd[r][k] = 8'((r * 37 + k * 53 + 11) % 256);
            req_data[r] = fd[r];
        end
        for (int g = 0; g < 5; g++) begin
            rsp_t rr;
            rr.id = g % N_REQ; rr.data = sort_vec(fd[g % N_REQ]); rr.err = 1'b0;
            exp_gnt.push_back(g % N_REQ);
            exp_rsp.push_back(rr);
        end
        rsp_ready = 1'b1;
        req = 4'b1111;
        cnt = 0;
        for (int c = 0; c < 200 && cnt < 5; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                cnt++;
                if (cnt == 5) req = '0;
            end
        end
        checkOutput("fair_grants", cnt, 5);
        waitIdle("fair_drain", 100);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        tick();
        d = {8'd200, 8'd17, 8'd66, 8'd3, 8'd128, 8'd90};
        e = sort_vec(d);
        applyStimulus(1, d, e, 1'b0, 1'b1);
        waitResponse(40, lat, gat, sat, scnt);
        checkOutput("bp_latency", lat, 11);
        tick();
        d2 = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
        applyStimulus(2, d2, sort_vec(d2), 1'b0, 1'b1);
        cnt = 0; scnt = 0; stable = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (gnt[2]) cnt++;
            if (sort_start) scnt++;
            if (rsp_valid && rsp_id == 2'd1 && rsp_data == e && !rsp_err) stable++;
            if (c == 5) begin spur_result = ~e; spur_en = 1'b1; spur_done = 1'b1; end
            if (c == 6) begin spur_done = 1'b0; spur_en = 1'b0; end
        end
        checkOutput("bp_no_gnt", cnt, 0);
        checkOutput("bp_no_start", scnt, 0);
        checkOutput("bp_stable", stable, 20);
        tick(); rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_idle_gnt", gnt, 0);
        @(negedge clk);
        checkOutput("bp_load_gnt", gnt, 4'b0100);
        req = '0;
        waitIdle("bp_drain", 60);

        $display("[TB] reset during wait");
        tick();
        d = {8'd77, 8'd1, 8'd2, 8'd250, 8'd9, 8'd33};
        applyStimulus(1, d, d, 1'b0, 1'b0);
        scnt = 0;
        for (int c = 0; c < 20 && scnt == 0; c++) begin
            @(negedge clk);
            if (gnt != '0) req = req & ~gnt;
            if (sort_start) scnt++;
        end
        checkOutput("abort_started", scnt, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_gnt", gnt, 0);
        checkOutput("abort_start", sort_start, 0);
        checkOutput("abort_valid", rsp_valid, 0);
        checkOutput("abort_id", rsp_id, 0);
        checkOutput("abort_data", rsp_data, 0);
        checkOutput("abort_sort_data", sort_data, 0);
        req = '0;
        tick(); rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        checkOutput("abort_no_rsp", cnt, 0);

        $display("[TB] duplicates after abort");
        tick();
        dup     = {8'd4, 8'd4, 8'd4, 8'd0, 8'd255, 8'd4};
        dup_exp = {8'd0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd255};
        applyStimulus(3, dup, dup_exp, 1'b0, 1'b1);
        waitResponse(40, lat, gat, sat, scnt);
        checkOutput("dup_latency", lat, 11);
        waitIdle("dup_drain", 20);

        $display("[TB] stray sort_done in idle");
        tick(); spur_done = 1'b1;
        tick(); spur_done = 1'b0;
        @(negedge clk);
        checkOutput("spur_idle_busy", busy, 0);
        checkOutput("spur_idle_valid", rsp_valid, 0);

        $display("[TB] hung sorter");
        sorter_hang = 1'b1;
        rsp_ready   = 1'b0;
        tick();
        d = {8'd8, 8'd6, 8'd4, 8'd2, 8'd1, 8'd3};
`ifdef SORT_ARB_TIMEOUT_EN
        applyStimulus(0, d, '0, 1'b1, 1'b1);
        waitResponse(200, lat, gat, sat, scnt);
        checkOutput("wdog_latency", lat, 67);
        checkOutput("wdog_err", rsp_err, 1);
        checkOutput("wdog_data", rsp_data, 0);
        tick(); rsp_ready = 1'b1;
        waitIdle("wdog_drain", 20);
`else
        applyStimulus(0, d, d, 1'b0, 1'b0);
        waitResponse(150, lat, gat, sat, scnt);
        checkOutput("hang_no_rsp", rsp_valid, 0);
        checkOutput("hang_busy", busy, 1);
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
`endif
        sorter_hang = 1'b0;
        tick();
        checkOutput("gnt_queue_empty", exp_gnt.size(), 0);
        checkOutput("rsp_queue_empty", exp_rsp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_arbiter.md
SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 Parameters SHALL be: N, 6, elements per sort job; WIDTH, 8, element width in bits; N_REQ, 4, number of requesters; TIMEOUT, 64, watchdog limit in cycles.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  N_REQ  per-requester job request, level.
- req_data  in  N_REQ x N x WIDTH  per-requester operand vector.
- gnt  out  N_REQ  one-hot capture acknowledge, one-cycle pulse.
- sort_start  out  1  start to the shared sorter.
- sort_data  out  N x WIDTH  operand to the sorter.
- sort_done  in  1  sorter completion pulse.
- sort_result  in  N x WIDTH  sorter output vector.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_id  out  clog2(N_REQ)  requester index of the response.
- rsp_data  out  N x WIDTH  sorted vector.
- rsp_err  out  1  job aborted by watchdog.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, START, WAIT and RESP, with one transition per clock at most.
REQ-004 In IDLE with req nonzero, the FSM SHALL pick a winner by round-robin from pointer rr_ptr, latch req_data[winner] into the operand register, latch the winner index and go to LOAD.
REQ-005 After a grant to index i, rr_ptr SHALL become (i+1) mod N_REQ, so index i has lowest priority in the next arbitration.
REQ-006 In LOAD, gnt[winner] SHALL be high for exactly that cycle and sort_start SHALL stay low; the next state SHALL be START.
REQ-007 A requester SHALL hold req and req_data stable until its gnt; req is sampled only in IDLE.
REQ-008 In START, sort_start SHALL be high for exactly one cycle; the next state SHALL be WAIT. sort_start SHALL be low in all other states, which guarantees at least 2 low cycles between jobs for the sorter's rising-edge detect.
REQ-009 sort_data SHALL equal the operand register and SHALL remain stable from LOAD until the FSM leaves WAIT.
REQ-010 In WAIT, sort_done=1 SHALL capture sort_result into rsp_data, set rsp_err=0 and move to RESP.
REQ-011 In RESP, rsp_valid, rsp_id, rsp_data and rsp_err SHALL be held until rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-012 In RESP, new requests SHALL NOT be arbitrated. rsp_ready and req high in the same cycle SHALL give the grant no earlier than the following IDLE cycle.
REQ-013 sort_done outside WAIT SHALL be ignored.
REQ-014 With a 6-element, 7-state sorter, rsp_valid SHALL first assert 11 cycles after the IDLE cycle that sampled req.

Reset
REQ-015 When rst_n=0, the block SHALL asynchronously force: state IDLE, rr_ptr 0, gnt 0, sort_start 0, rsp_valid 0, rsp_err 0, busy 0, rsp_id 0, rsp_data 0, operand register 0, watchdog counter 0.
REQ-016 Reset mid-job SHALL discard the job without a response. The sorter SHALL share the same reset net.

Configuration
REQ-017 With macro SORT_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle. When it reaches TIMEOUT without sort_done, the FSM SHALL go to RESP with rsp_err=1 and rsp_data=0. If sort_done and the timeout occur in the same cycle, sort_done SHALL win.
REQ-018 With SORT_ARB_TIMEOUT_EN undefined, no counter SHALL be built, rsp_err SHALL be tied 0 and WAIT SHALL have no exit other than sort_done.

Verification
REQ-019 Single request: req=0001, req_data[0]={5,3,9,1,7,2} -> gnt=0001 one pulse; sort_start one pulse; rsp_valid after 11 cycles; rsp_id=0; rsp_data={1,2,3,5,7,9}.
REQ-020 Fairness: req=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each gnt exactly one cycle.
REQ-021 Backpressure: rsp_ready=0 for 20 cycles with req[2]=1 -> response held stable, no gnt[2], sort_start low; release -> gnt[2] in LOAD 2 cycles later.
REQ-022 Reset mid-WAIT: rst_n=0 for 1 cycle -> all outputs 0 immediately; no rsp_valid for the aborted job; the next job completes normally.
REQ-023 Timeout (macro defined, TIMEOUT=64, sort_done never asserted) -> rsp_valid with rsp_err=1 and rsp_data all 0 after 64 WAIT cycles; without the macro, busy stays high.
REQ-024 Duplicates: req_data={4,4,4,0,255,4} -> rsp_data={0,4,4,4,4,255}.
